ccff_bitstream_loader: RTL and testbench
========================================

CCFF_BITSTREAM_LOADER -- requirements
Module: ccff_bitstream_loader

Interface
REQ-001 Parameter WORD_W, default 8: width of each configuration word accepted from the host.
REQ-002 Parameter CHAIN_LEN, default 12: total number of configuration flops in the downstream ccff chain.
REQ-003 prog_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 prog_reset  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  single-cycle pulse that begins a load; honoured only in IDLE or DONE.
REQ-006 cfg_data  input  [WORD_W-1:0]  configuration word, shifted out MSB first.
REQ-007 cfg_valid  input  1  cfg_data is valid.
REQ-008 cfg_ready  output  1  loader accepts cfg_data this cycle.
REQ-009 ccff_head  output  1  serial bit driven into the chain's ccff_head.
REQ-010 chain_clk_en  output  1  enable for the chain's gated prog_clk; the chain captures ccff_head on each edge where this is 1.
REQ-011 cfg_busy  output  1  a load is in progress.
REQ-012 cfg_done  output  1  all CHAIN_LEN bits have been shifted.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-014 IDLE->SHIFT on start; SHIFT->DONE on the edge that shifts bit CHAIN_LEN; DONE->SHIFT on start; DONE is otherwise held.
REQ-015 On entry to SHIFT, bit counter and word buffers SHALL clear; cfg_busy=1 only in SHIFT; cfg_done=1 only in DONE.
REQ-016 The loader SHALL hold two word stages: an active shift register and a one-word holding buffer.
REQ-017 cfg_ready SHALL be 1 only in SHIFT, with the holding buffer empty and fewer than ceil(CHAIN_LEN/WORD_W) words accepted since start.
REQ-018 A word is accepted on an edge where cfg_valid=1 and cfg_ready=1; cfg_data SHALL be ignored at all other times, including in IDLE and DONE.
REQ-019 When the active register is empty and the buffer is full, the buffered word SHALL move to the active register on the same edge, so a host holding cfg_valid=1 streams with no gap cycles.
REQ-020 chain_clk_en and ccff_head SHALL be registered; chain_clk_en=1 exactly in cycles where ccff_head carries a valid, not-yet-shifted bit.
REQ-021 Bits SHALL leave each word MSB first; the first bit shifted after start ends up in the chain flop furthest from ccff_head.
REQ-022 Exactly CHAIN_LEN cycles SHALL have chain_clk_en=1 per load.
REQ-023 In the final word, the bits beyond the CHAIN_LEN total (its low-order bits) SHALL be discarded and never shifted.
REQ-024 Underrun: if no bit is available, chain_clk_en=0 and ccff_head holds its last value; shifting SHALL resume when the next word arrives, with no bit lost or duplicated.
REQ-025 The bit counter SHALL be $clog2(CHAIN_LEN+1) bits wide and SHALL NOT wrap.
REQ-026 start during SHIFT SHALL be ignored.
REQ-027 start together with cfg_valid in IDLE: that cfg_data SHALL NOT be accepted; cfg_ready rises the cycle after.

Reset
REQ-028 While prog_reset=1 at an edge, the FSM SHALL enter IDLE and counters and buffers SHALL clear.
REQ-029 After that reset edge: cfg_ready=0, chain_clk_en=0, ccff_head=0, cfg_busy=0, cfg_done=0.
REQ-030 prog_reset SHALL take priority over start and over handshakes on the same edge.
REQ-031 Reset mid-SHIFT SHALL abort the load, with chain_clk_en=0 from the next cycle; a new start is then required.

Verification
REQ-032 Continuous stream, WORD_W=8, CHAIN_LEN=12: start, then 0xA5 and 0x3C back-to-back with cfg_valid held. Required: ccff_head = 1,0,1,0,0,1,0,1,0,0,1,1 on 12 consecutive chain_clk_en=1 cycles; low nibble 0xC never shifted; cfg_done=1 the cycle after the 12th bit; only 2 words accepted.
REQ-033 Underrun: 0xFF sent, then cfg_valid=0 for 5 cycles, then 0x00. Required: 8 enabled cycles of 1, then 5 cycles with chain_clk_en=0, then 4 enabled cycles of 0; total enabled cycles = 12.
REQ-034 Reset mid-load: prog_reset asserted after 5 shifted bits. Required: the REQ-029 reset values hold the cycle after reset; a later start reloads all 12 bits from word 0.
REQ-035 Ignored inputs: cfg_valid=1 in IDLE, and start pulsed mid-SHIFT. Required: no word accepted in IDLE; the bit count and sequence of the load in progress are unchanged.
REQ-036 Reload from DONE: start, then 0x0F and 0xF0. Required: cfg_done drops, cfg_busy rises, and the new 12-bit sequence 0,0,0,0,1,1,1,1,1,1,1,1 is shifted.

Source files
------------

// File: rtl/ccff_bitstream_loader.sv
// Serialises host configuration words, MSB first, into a ccff configuration chain.
// It uses a shift register and a one-word holding buffer so that a streaming host sees no gap cycles.
module ccff_bitstream_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 12
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              chain_clk_en,
    output logic              cfg_busy,
    output logic              cfg_done
);

    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int BIT_W  = $clog2(CHAIN_LEN + 1);
    localparam int ACT_W  = $clog2(WORD_W + 1);
    localparam int WCNT_W = $clog2(NWORDS + 1);

    localparam logic [BIT_W-1:0]  LAST_BIT     = BIT_W'(CHAIN_LEN);
    localparam logic [WCNT_W-1:0] MAX_WORDS    = WCNT_W'(NWORDS);
    localparam logic [ACT_W-1:0]  WORD_BITS_M1 = ACT_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [WORD_W-1:0]   act_word;
    logic [WORD_W-1:0]   hold_word;
    logic [ACT_W-1:0]    act_cnt;
    logic                hold_full;
    logic [WCNT_W-1:0]   word_cnt;
    logic [BIT_W-1:0]    bit_cnt;

    logic                from_act;
    logic                from_hold;
    logic                emit;
    logic                next_bit;
    logic                accept;
    logic                hold_full_nxt;
    logic [WCNT_W-1:0]   word_cnt_nxt;

    // Bit source selection and next-cycle handshake bookkeeping.
    always_comb begin
        from_act      = 1'b0;
        from_hold     = 1'b0;
        next_bit      = 1'b0;
        accept        = cfg_valid & cfg_ready;
        if (bit_cnt < LAST_BIT) begin
            if (act_cnt != {ACT_W{1'b0}}) begin
                from_act = 1'b1;
                next_bit = act_word[WORD_W-1];
            end else if (hold_full) begin
                // The buffered word moves up and supplies its MSB on the same edge.
                from_hold = 1'b1;
                next_bit  = hold_word[WORD_W-1];
            end else begin
                next_bit = 1'b0;
            end
        end else begin
            next_bit = 1'b0;
        end
        emit          = from_act | from_hold;
        hold_full_nxt = accept | (hold_full & ~from_hold);
        word_cnt_nxt  = word_cnt + WCNT_W'(accept);
    end

    // Loader FSM, word stages, counters and registered outputs.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state        <= IDLE;
            act_word     <= {WORD_W{1'b0}};
            hold_word    <= {WORD_W{1'b0}};
            act_cnt      <= {ACT_W{1'b0}};
            hold_full    <= 1'b0;
            word_cnt     <= {WCNT_W{1'b0}};
            bit_cnt      <= {BIT_W{1'b0}};
            cfg_ready    <= 1'b0;
            ccff_head    <= 1'b0;
            chain_clk_en <= 1'b0;
            cfg_busy     <= 1'b0;
            cfg_done     <= 1'b0;
        end else if (start && (state != SHIFT)) begin
            state        <= SHIFT;
            act_word     <= {WORD_W{1'b0}};
            hold_word    <= {WORD_W{1'b0}};
            act_cnt      <= {ACT_W{1'b0}};
            hold_full    <= 1'b0;
            word_cnt     <= {WCNT_W{1'b0}};
            bit_cnt      <= {BIT_W{1'b0}};
            cfg_ready    <= 1'b1;
            chain_clk_en <= 1'b0;
            cfg_busy     <= 1'b1;
            cfg_done     <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    if (chain_clk_en && (bit_cnt == LAST_BIT)) begin
                        state        <= DONE;
                        chain_clk_en <= 1'b0;
                        cfg_ready    <= 1'b0;
                        cfg_busy     <= 1'b0;
                        cfg_done     <= 1'b1;
                    end else begin
                        if (from_act) begin
                            act_word <= {act_word[WORD_W-2:0], 1'b0};
                            act_cnt  <= act_cnt - ACT_W'(1);
                        end else if (from_hold) begin
                            act_word <= {hold_word[WORD_W-2:0], 1'b0};
                            act_cnt  <= WORD_BITS_M1;
                        end else begin
                            act_word <= act_word;
                        end
                        if (accept) begin
                            hold_word <= cfg_data;
                        end else begin
                            hold_word <= hold_word;
                        end
                        // On underrun the head keeps its last value and the enable drops.
                        if (emit) begin
                            ccff_head <= next_bit;
                            bit_cnt   <= bit_cnt + BIT_W'(1);
                        end else begin
                            ccff_head <= ccff_head;
                        end
                        hold_full    <= hold_full_nxt;
                        word_cnt     <= word_cnt_nxt;
                        chain_clk_en <= emit;
                        cfg_ready    <= ~hold_full_nxt && (word_cnt_nxt < MAX_WORDS);
                    end
                end
                IDLE, DONE: begin
                    state        <= state;
                    chain_clk_en <= 1'b0;
                    cfg_ready    <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    chain_clk_en <= 1'b0;
                    cfg_ready    <= 1'b0;
                    cfg_busy     <= 1'b0;
                    cfg_done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader: streaming, underrun, reset abort,
// ignored inputs and reload, with hand-computed chain bit sequences.
module tb_ccff_bitstream_loader;

    logic       prog_clk = 1'b0;
    logic       prog_reset;
    logic       start;
    logic [7:0] cfg_data;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       ccff_head;
    logic       chain_clk_en;
    logic       cfg_busy;
    logic       cfg_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int accepted;
    int en_cnt;
    int done_cyc;
    logic [7:0] host_q[$];
    logic       bits[$];
    int         en_cyc[$];

    ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(12)) dut (
        .prog_clk    (prog_clk),
        .prog_reset  (prog_reset),
        .start       (start),
        .cfg_data    (cfg_data),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .ccff_head   (ccff_head),
        .chain_clk_en(chain_clk_en),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: host handshake bookkeeping plus a record of every enabled chain cycle.
    task automatic step();
        logic acc;
        acc = cfg_valid && cfg_ready && !prog_reset;
        @(posedge prog_clk);
        #1;
        start = 1'b0;
        cyc++;
        if (acc) begin
            accepted++;
            if (host_q.size() > 0) cfg_data = host_q.pop_front();
            else cfg_valid = 1'b0;
        end
        if (chain_clk_en) begin
            bits.push_back(ccff_head);
            en_cyc.push_back(cyc);
            en_cnt++;
        end
        if (cfg_done && done_cyc < 0) done_cyc = cyc;
    endtask

    task automatic begin_load(input logic [7:0] w0);
        bits.delete();
        en_cyc.delete();
        en_cnt    = 0;
        accepted  = 0;
        done_cyc  = -1;
        start     = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = w0;
    endtask

    task automatic run_to_done();
        for (int i = 0; i < 60 && !cfg_done; i++) step();
    endtask

    function automatic logic [11:0] packed_bits();
        logic [11:0] v;
        v = 12'h000;
        foreach (bits[i]) v = {v[10:0], bits[i]};
        return v;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(cfg_ready),    32'd0);
        chk({tag, "_en"},    32'(chain_clk_en), 32'd0);
        chk({tag, "_head"},  32'(ccff_head),    32'd0);
        chk({tag, "_busy"},  32'(cfg_busy),     32'd0);
        chk({tag, "_done"},  32'(cfg_done),     32'd0);
    endtask

    initial begin
        prog_reset = 1'b1;
        start      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_data   = 8'h00;
        accepted   = 0;
        en_cnt     = 0;
        done_cyc   = -1;
        step();
        step();
        prog_reset = 1'b0;
        chk_reset_outputs("reset");

        // cfg_valid in IDLE must be ignored.
        cfg_valid = 1'b1;
        cfg_data  = 8'h55;
        for (int i = 0; i < 3; i++) step();
        chk("idle_accept", 32'(accepted), 32'd0);
        chk("idle_ready",  32'(cfg_ready), 32'd0);
        chk("idle_busy",   32'(cfg_busy),  32'd0);

        // Continuous stream 0xA5, 0x3C; start coincides with cfg_valid.
        begin_load(8'hA5);
        host_q = '{8'h3C};
        step();
        chk("start_no_accept", 32'(accepted), 32'd0);
        chk("start_ready",     32'(cfg_ready), 32'd1);
        chk("start_busy",      32'(cfg_busy),  32'd1);
        run_to_done();
        chk("stream_done",    32'(cfg_done),     32'd1);
        chk("stream_bits",    32'(packed_bits()), 32'h0A53);
        chk("stream_en_cnt",  32'(en_cnt),       32'd12);
        chk("stream_words",   32'(accepted),     32'd2);
        chk("stream_no_gap",  32'(en_cyc[11] - en_cyc[0]), 32'd11);
        chk("stream_done_at", 32'(done_cyc - en_cyc[11]),  32'd1);
        chk("stream_busy",    32'(cfg_busy),     32'd0);
        for (int i = 0; i < 3; i++) step();
        chk("done_hold",      32'(cfg_done),     32'd1);
        chk("done_en",        32'(chain_clk_en), 32'd0);

        // Reload from DONE with 0x0F, 0xF0 and a start pulse mid-SHIFT.
        begin_load(8'h0F);
        host_q = '{8'hF0};
        step();
        chk("reload_done_drop", 32'(cfg_done), 32'd0);
        chk("reload_busy",      32'(cfg_busy), 32'd1);
        for (int i = 0; i < 40 && en_cnt < 3; i++) step();
        start = 1'b1;
        step();
        run_to_done();
        chk("reload_done",   32'(cfg_done),      32'd1);
        chk("reload_bits",   32'(packed_bits()), 32'h00FF);
        chk("reload_en_cnt", 32'(en_cnt),        32'd12);
        chk("reload_words",  32'(accepted),      32'd2);

        // Underrun: 0xFF, then the host stalls until a 5-cycle gap, then 0x00.
        begin_load(8'hFF);
        host_q.delete();
        step();
        for (int i = 0; i < 40 && en_cnt < 8; i++) step();
        chk("under_first8", 32'(en_cnt), 32'd8);
        for (int i = 0; i < 4; i++) step();
        chk("under_stall_en",   32'(chain_clk_en), 32'd0);
        chk("under_stall_head", 32'(ccff_head),    32'd1);
        cfg_valid = 1'b1;
        cfg_data  = 8'h00;
        run_to_done();
        chk("under_done",    32'(cfg_done),      32'd1);
        chk("under_bits",    32'(packed_bits()), 32'hFF0);
        chk("under_en_cnt",  32'(en_cnt),        32'd12);
        chk("under_gap",     32'(en_cyc[8] - en_cyc[7] - 1), 32'd5);
        chk("under_tail",    32'(en_cyc[11] - en_cyc[8]),    32'd3);

        // Reset after 5 shifted bits aborts the load; a new start reloads from word 0.
        begin_load(8'hA5);
        host_q = '{8'h3C};
        step();
        for (int i = 0; i < 40 && en_cnt < 5; i++) step();
        chk("abort_pre_cnt", 32'(en_cnt), 32'd5);
        prog_reset = 1'b1;
        start      = 1'b1;
        cfg_valid  = 1'b1;
        step();
        prog_reset = 1'b0;
        cfg_valid  = 1'b0;
        chk_reset_outputs("abort");
        for (int i = 0; i < 3; i++) step();
        chk("abort_idle_en",   32'(en_cnt),   32'd5);
        chk("abort_idle_busy", 32'(cfg_busy), 32'd0);
        begin_load(8'hA5);
        host_q = '{8'h3C};
        step();
        run_to_done();
        chk("again_done",    32'(cfg_done),      32'd1);
        chk("again_bits",    32'(packed_bits()), 32'h0A53);
        chk("again_en_cnt",  32'(en_cnt),        32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
